dual_issue_scheduler: RTL and testbench
=======================================

# dual_issue_scheduler

In-order dual-issue scheduler that sits between instruction decode and the even/odd execution pipes. It holds one decoded instruction pair and issues each instruction to its pipe only when no structural, intra-pair or register hazard exists. Hazards are checked against a 128-entry register busy scoreboard sized to the per-instruction result latency, so forwarding covers everything the scheduler lets through. It also honours branch flushes from the odd pipe.

## Interface
- PAYLOAD_W, 64: width of the opaque per-instruction payload (opcode, immediates) passed through to the pipes.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  decode presents a pair.
- in_ready  out  1  pair accepted on an edge where in_valid & in_ready.
- a_*/b_* (slot A is older, slot B younger), each slot:
  - x_valid  in  1  slot holds an instruction.
  - x_pipe  in  1  0 = even, 1 = odd.
  - x_ra, x_rb, x_rc, x_rt  in  7 each  register addresses.
  - x_use_ra, x_use_rb, x_use_rc  in  1 each  source is read.
  - x_wr_rt  in  1  instruction writes rt.
  - x_lat  in  3  cycles until the result is forwardable (1..7; 0 is treated as 1).
  - x_payload  in  PAYLOAD_W  passed through.
- branch_taken  in  1  flush request.
- ep_valid, op_valid  out  1  instruction issued to the even/odd pipe this cycle.
- ep_payload, op_payload  out  PAYLOAD_W  issued payload; 0 when not valid.
- ep_rt, op_rt  out  7  issued destination; 0 when not valid.
- stall_cycles  out  32  count of cycles with a held instruction that did not issue.

## Operation
- Holding register: two slots, HA (oldest) and HB, each with valid/fields. Loaded from a_/b_ on accept. An invalid a_ with a valid b_ is compacted into HA.
- in_ready = both slots are empty, or every valid held instruction issues this cycle, and branch_taken = 0.
- Scoreboard: busy[0..127], 3 bits each. At each edge every nonzero entry decrements by 1. An issuing instruction with wr_rt sets busy[rt] = lat-1. Issue takes priority over the decrement for the same entry. If two instructions target the same rt on one edge, the larger value wins.
- A source is ready when busy[src] == 0 or the source is unused. r0 gets no special treatment.
- HA may issue when all its used sources are ready, and when wr_rt implies busy[rt] < lat (WAW ordering).
- HB may issue in the same cycle only when all of these hold:
  - HA issues.
  - HB.pipe != HA.pipe.
  - HB does not read HA.rt when HA.wr_rt.
  - HB.rt != HA.rt when both write.
  - HB passes its own source and WAW checks.
- If HA does not issue, HB never issues (strict in-order).
- After HA issues alone, HB moves to HA and is rechecked next cycle. A new pair is not accepted until the holding register empties.
- Issued instructions drive ep_*/op_* by their pipe field.
- Flush: branch_taken = 1 at an edge clears both slots, suppresses that cycle's issue (ep_valid = op_valid = 0 next cycle) and does not update the scoreboard from the suppressed instructions. In-flight busy counts continue to decrement.
- stall_cycles increments (wrapping at 2^32) on each edge where HA is valid, HA does not issue, and branch_taken = 0.

## Timing
- Reset values:
  - in_ready = 1.
  - ep_valid = op_valid = 0.
  - payloads and rt outputs = 0.
  - stall_cycles = 0.
  - busy[] = 0.
  - slots empty.
- Reset mid-operation drops the held and scoreboard state in the same edge.
- A pair accepted at edge t is in the holding register during cycle t+1. Its issue decision is combinational in t+1, and the issue outputs are registered, so they are visible in cycle t+2.
- A producer issued (outputs visible) in cycle p with latency L allows a consumer to be visible on the issue outputs no earlier than cycle p+L. So L = 1 gives back-to-back issue.
- Throughput: at most one instruction per pipe per cycle, and at most one accepted pair per cycle.
- Simultaneous branch_taken with in_valid: the pair is not accepted (in_ready = 0).

## Test plan
- Reset, then pair {A: even il r1 lat 2, B: odd lnop} → ep_valid = 1 and ep_rt = 1 two cycles after accept; op_valid = 1 in the same cycle; in_ready stays 1.
- Next pair {A: even a r16 = r1+r3 lat 2} presented immediately → one stall cycle; it issues one cycle later than a dependency-free pair; stall_cycles = 1.
- Pair {A: even rt = 5, B: even rt = 6}, no dependencies → A issues on ep in cycle n, B on ep in n+1; in_ready low in n, high in n+1.
- Pair {A: odd shlqbii r17 lat 4, B: even reads ra = 17} → A issues; B issues exactly 4 cycles later; ep_valid = 0 in between.
- WAW: in flight busy[5] = 6 (mpy lat 7), then a new lat 2 write to r5 → held until busy[5] ≤ 1, then issues.
- Hold a stalled pair, assert branch_taken → slots cleared; no issue the next cycle; in_ready = 1 afterwards. Reset asserted mid-stall → all outputs and stall_cycles return to 0 on the next cycle.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: holds one decoded pair, issues to even/odd pipes past a register busy scoreboard.
// Latency: pair accepted at edge t issues (registered outputs) no earlier than edge t+1; one stall cycle per hazard cycle.
// Backpressure: in_ready drops while held instructions remain unissued or a branch flush is requested.
module dual_issue_scheduler #(
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 a_valid,
    input  logic                 a_pipe,
    input  logic [6:0]           a_ra,
    input  logic [6:0]           a_rb,
    input  logic [6:0]           a_rc,
    input  logic [6:0]           a_rt,
    input  logic                 a_use_ra,
    input  logic                 a_use_rb,
    input  logic                 a_use_rc,
    input  logic                 a_wr_rt,
    input  logic [2:0]           a_lat,
    input  logic [PAYLOAD_W-1:0] a_payload,
    input  logic                 b_valid,
    input  logic                 b_pipe,
    input  logic [6:0]           b_ra,
    input  logic [6:0]           b_rb,
    input  logic [6:0]           b_rc,
    input  logic [6:0]           b_rt,
    input  logic                 b_use_ra,
    input  logic                 b_use_rb,
    input  logic                 b_use_rc,
    input  logic                 b_wr_rt,
    input  logic [2:0]           b_lat,
    input  logic [PAYLOAD_W-1:0] b_payload,
    input  logic                 branch_taken,
    output logic                 ep_valid,
    output logic [PAYLOAD_W-1:0] ep_payload,
    output logic [6:0]           ep_rt,
    output logic                 op_valid,
    output logic [PAYLOAD_W-1:0] op_payload,
    output logic [6:0]           op_rt,
    output logic [31:0]          stall_cycles
);

    typedef struct packed {
        logic                 vld;
        logic                 pipe;
        logic [6:0]           ra;
        logic [6:0]           rb;
        logic [6:0]           rc;
        logic [6:0]           rt;
        logic                 use_ra;
        logic                 use_rb;
        logic                 use_rc;
        logic                 wr_rt;
        logic [2:0]           lat;
        logic [PAYLOAD_W-1:0] payload;
    } slot_t;

    slot_t ha_q, hb_q;
    slot_t in_a, in_b, ld_a, ld_b;

    logic [127:0][2:0] busy, busy_nxt;

    logic ha_ok, hb_ok, ha_issue, hb_issue;
    logic ha_set, hb_set;
    logic [2:0] ha_val, hb_val;

    logic                 ep_sel, op_sel;
    logic [PAYLOAD_W-1:0] ep_pay, op_pay;
    logic [6:0]           ep_dst, op_dst;

    function automatic logic slot_ready(input slot_t s, input logic [127:0][2:0] bsy);
        logic ok;
        ok = (!s.use_ra || bsy[s.ra] == 3'd0)
          && (!s.use_rb || bsy[s.rb] == 3'd0)
          && (!s.use_rc || bsy[s.rc] == 3'd0)
          && (!s.wr_rt  || bsy[s.rt] < s.lat);
        return ok;
    endfunction

    function automatic logic reads_reg(input slot_t s, input logic [6:0] r);
        return (s.use_ra && s.ra == r) || (s.use_rb && s.rb == r) || (s.use_rc && s.rc == r);
    endfunction

    // Latency 0 is stored as 1 so the scoreboard never sees an underflowed lat-1.
    always_comb begin
        in_a         = '0;
        in_a.vld     = a_valid;
        in_a.pipe    = a_pipe;
        in_a.ra      = a_ra;
        in_a.rb      = a_rb;
        in_a.rc      = a_rc;
        in_a.rt      = a_rt;
        in_a.use_ra  = a_use_ra;
        in_a.use_rb  = a_use_rb;
        in_a.use_rc  = a_use_rc;
        in_a.wr_rt   = a_wr_rt;
        in_a.lat     = (a_lat == 3'd0) ? 3'd1 : a_lat;
        in_a.payload = a_payload;
        in_b         = '0;
        in_b.vld     = b_valid;
        in_b.pipe    = b_pipe;
        in_b.ra      = b_ra;
        in_b.rb      = b_rb;
        in_b.rc      = b_rc;
        in_b.rt      = b_rt;
        in_b.use_ra  = b_use_ra;
        in_b.use_rb  = b_use_rb;
        in_b.use_rc  = b_use_rc;
        in_b.wr_rt   = b_wr_rt;
        in_b.lat     = (b_lat == 3'd0) ? 3'd1 : b_lat;
        in_b.payload = b_payload;
        ld_a = in_a.vld ? in_a : in_b;
        ld_b = in_a.vld ? in_b : '0;
    end

    always_comb begin
        ha_ok = ha_q.vld && slot_ready(ha_q, busy);
        hb_ok = hb_q.vld
             && (hb_q.pipe != ha_q.pipe)
             && !(ha_q.wr_rt && reads_reg(hb_q, ha_q.rt))
             && !(ha_q.wr_rt && hb_q.wr_rt && hb_q.rt == ha_q.rt)
             && slot_ready(hb_q, busy);
        ha_issue = ha_ok && !branch_taken;
        hb_issue = ha_issue && hb_ok;
        in_ready = !branch_taken && (!ha_q.vld || ha_issue) && (!hb_q.vld || hb_issue);
    end

    // Issue overrides the per-edge decrement; on a same-register collision the larger count wins.
    always_comb begin
        ha_set = ha_issue && ha_q.wr_rt;
        hb_set = hb_issue && hb_q.wr_rt;
        ha_val = ha_q.lat - 3'd1;
        hb_val = hb_q.lat - 3'd1;
        busy_nxt = '0;
        for (int i = 0; i < 128; i++) begin
            busy_nxt[i] = (busy[i] != 3'd0) ? busy[i] - 3'd1 : 3'd0;
            if (ha_set && ha_q.rt == 7'(i)) begin
                busy_nxt[i] = ha_val;
            end
            if (hb_set && hb_q.rt == 7'(i) && (!(ha_set && ha_q.rt == 7'(i)) || hb_val > ha_val)) begin
                busy_nxt[i] = hb_val;
            end
        end
    end

    always_comb begin
        ep_sel = 1'b0;
        ep_pay = '0;
        ep_dst = '0;
        op_sel = 1'b0;
        op_pay = '0;
        op_dst = '0;
        if (ha_issue) begin
            if (ha_q.pipe) begin
                op_sel = 1'b1;
                op_pay = ha_q.payload;
                op_dst = ha_q.rt;
            end else begin
                ep_sel = 1'b1;
                ep_pay = ha_q.payload;
                ep_dst = ha_q.rt;
            end
        end
        // HB only issues on the pipe HA left free.
        if (hb_issue) begin
            if (hb_q.pipe) begin
                op_sel = 1'b1;
                op_pay = hb_q.payload;
                op_dst = hb_q.rt;
            end else begin
                ep_sel = 1'b1;
                ep_pay = hb_q.payload;
                ep_dst = hb_q.rt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || branch_taken) begin
            ha_q <= '0;
            hb_q <= '0;
        end else if (in_valid && in_ready) begin
            ha_q <= ld_a;
            hb_q <= ld_b;
        end else if (hb_issue) begin
            ha_q <= '0;
            hb_q <= '0;
        end else if (ha_issue) begin
            ha_q <= hb_q;
            hb_q <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ep_valid   <= 1'b0;
            ep_payload <= '0;
            ep_rt      <= '0;
            op_valid   <= 1'b0;
            op_payload <= '0;
            op_rt      <= '0;
        end else begin
            ep_valid   <= ep_sel;
            ep_payload <= ep_pay;
            ep_rt      <= ep_dst;
            op_valid   <= op_sel;
            op_payload <= op_pay;
            op_rt      <= op_dst;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (ha_q.vld && !ha_issue && !branch_taken) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: vector table of pairs plus hand sequences for stalls, flush and reset.
module tb_dual_issue_scheduler;

    typedef struct packed {
        logic        v;
        logic        pipe;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic [6:0]  rt;
        logic        ura;
        logic        urb;
        logic        urc;
        logic        wr;
        logic [2:0]  lat;
        logic [63:0] pay;
    } ins_t;

    typedef struct {
        ins_t a;
        ins_t b;
        int   da;
        int   db;
        bit   rdy1;
    } vec_t;

    typedef struct {
        logic [6:0]  rt;
        logic [63:0] pay;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        branch_taken;
    ins_t        ai, bi;
    logic        ep_valid, op_valid;
    logic [63:0] ep_payload, op_payload;
    logic [6:0]  ep_rt, op_rt;
    logic [31:0] stall_cycles;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    exp_t eq[$];
    exp_t oq[$];
    vec_t vt[9];

    dual_issue_scheduler #(.PAYLOAD_W(64)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_valid(ai.v), .a_pipe(ai.pipe), .a_ra(ai.ra), .a_rb(ai.rb), .a_rc(ai.rc), .a_rt(ai.rt),
        .a_use_ra(ai.ura), .a_use_rb(ai.urb), .a_use_rc(ai.urc), .a_wr_rt(ai.wr),
        .a_lat(ai.lat), .a_payload(ai.pay),
        .b_valid(bi.v), .b_pipe(bi.pipe), .b_ra(bi.ra), .b_rb(bi.rb), .b_rc(bi.rc), .b_rt(bi.rt),
        .b_use_ra(bi.ura), .b_use_rb(bi.urb), .b_use_rc(bi.urc), .b_wr_rt(bi.wr),
        .b_lat(bi.lat), .b_payload(bi.pay),
        .branch_taken(branch_taken),
        .ep_valid(ep_valid), .ep_payload(ep_payload), .ep_rt(ep_rt),
        .op_valid(op_valid), .op_payload(op_payload), .op_rt(op_rt),
        .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic ins_t mk(input logic pipe, input int rt, input logic wr, input int lat,
                                input int ra, input logic ura, input int rb, input logic urb,
                                input int rc, input logic urc);
        ins_t s;
        s.v    = 1'b1;
        s.pipe = pipe;
        s.rt   = 7'(rt);
        s.wr   = wr;
        s.lat  = 3'(lat);
        s.ra   = 7'(ra);
        s.ura  = ura;
        s.rb   = 7'(rb);
        s.urb  = urb;
        s.rc   = 7'(rc);
        s.urc  = urc;
        s.pay  = {$urandom, $urandom};
        return s;
    endfunction

    task automatic push_exp(input ins_t s, input int at);
        exp_t e;
        e.rt  = s.rt;
        e.pay = s.pay;
        e.cyc = at;
        if (s.pipe) oq.push_back(e);
        else        eq.push_back(e);
    endtask

    // Presents a pair from the next falling edge until accepted; d* are edges after the accept edge.
    task automatic send_pair(input ins_t a, input ins_t b, input int da, input int db,
                             input bit push, output int waited);
        int e;
        waited = 0;
        @(negedge clock);
        ai = a;
        bi = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            waited++;
            if (waited > 200) begin
                flag("accept_timeout");
                in_valid = 1'b0;
                return;
            end
            @(negedge clock);
            #1;
        end
        e = cyc + 1;
        if (push) begin
            if (a.v) push_exp(a, e + da);
            if (b.v) push_exp(b, e + db);
        end
        @(posedge clock);
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        in_valid = 1'b0;
        ai = '0;
        bi = '0;
        branch_taken = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (ep_valid) begin
                    if (eq.size() == 0) flag("ep_unexpected_issue");
                    else begin
                        e = eq.pop_front();
                        chk("ep_issue_cycle", 64'(cyc), 64'(e.cyc));
                        chk("ep_rt", 64'(ep_rt), 64'(e.rt));
                        chk("ep_payload", ep_payload, e.pay);
                    end
                end else begin
                    chk("ep_idle_zero", 64'(ep_rt) | ep_payload, 64'd0);
                end
                if (op_valid) begin
                    if (oq.size() == 0) flag("op_unexpected_issue");
                    else begin
                        e = oq.pop_front();
                        chk("op_issue_cycle", 64'(cyc), 64'(e.cyc));
                        chk("op_rt", 64'(op_rt), 64'(e.rt));
                        chk("op_payload", op_payload, e.pay);
                    end
                end else begin
                    chk("op_idle_zero", 64'(op_rt) | op_payload, 64'd0);
                end
            end
        end
    endtask

    initial begin
        int   w;
        int   s0;
        ins_t none;
        none = '0;
        reset = 1'b1;
        in_valid = 1'b0;
        branch_taken = 1'b0;
        ai = '0;
        bi = '0;

        //            pipe rt wr lat  ra ura rb urb rc urc
        vt[0] = '{mk(0, 5,  1, 1, 0, 0, 0, 0, 0, 0),  mk(0, 6,  1, 1, 0, 0, 0, 0, 0, 0), 1, 2, 0};
        vt[1] = '{mk(0, 7,  1, 2, 0, 0, 0, 0, 0, 0),  mk(1, 8,  1, 2, 0, 0, 0, 0, 0, 0), 1, 1, 1};
        vt[2] = '{mk(1, 17, 1, 4, 0, 0, 0, 0, 0, 0),  mk(0, 30, 1, 1, 17, 1, 0, 0, 0, 0), 1, 5, 0};
        vt[3] = '{mk(0, 10, 1, 3, 0, 0, 0, 0, 0, 0),  mk(1, 10, 1, 1, 0, 0, 0, 0, 0, 0), 1, 4, 0};
        vt[4] = '{none,                               mk(1, 3,  1, 0, 0, 0, 0, 0, 0, 0), 0, 1, 1};
        vt[5] = '{mk(0, 4,  1, 0, 0, 0, 0, 0, 0, 0),  mk(1, 31, 1, 1, 0, 0, 4, 1, 0, 0), 1, 2, 0};
        vt[6] = '{mk(1, 13, 1, 3, 0, 0, 0, 0, 12, 1), mk(0, 14, 1, 1, 13, 0, 2, 1, 0, 0), 1, 1, 1};
        vt[7] = '{mk(0, 21, 0, 5, 0, 0, 0, 0, 0, 0),  mk(1, 40, 1, 1, 21, 1, 0, 0, 0, 0), 1, 1, 1};
        vt[8] = '{mk(1, 22, 1, 1, 0, 0, 0, 0, 0, 0),  mk(1, 23, 1, 1, 0, 0, 0, 0, 0, 0), 1, 2, 0};

        fork
            monitor();
        join_none

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_ep_valid", 64'(ep_valid), 64'd0);
        chk("reset_op_valid", 64'(op_valid), 64'd0);
        chk("reset_ep_zero", 64'(ep_rt) | ep_payload, 64'd0);
        chk("reset_op_zero", 64'(op_rt) | op_payload, 64'd0);
        chk("reset_stall", 64'(stall_cycles), 64'd0);
        mon_en = 1'b1;

        // il r1 lat 2 with lnop, then a r16 = r1 + r3 right behind it: one stall.
        send_pair(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0), mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1, 1, 1, w);
        send_pair(mk(0, 16, 1, 2, 1, 1, 3, 1, 0, 0), none, 2, 0, 1, w);
        chk("plan_in_ready_held_high", 64'(w), 64'd0);
        idle(4);
        chk("plan_stall_one", 64'(stall_cycles), 64'd1);

        // WAW: mpy r5 lat 7 then a lat 2 write of r5 waits until busy[5] <= 1.
        s0 = stall_cycles;
        send_pair(mk(0, 5, 1, 7, 0, 0, 0, 0, 0, 0), none, 1, 0, 1, w);
        send_pair(mk(0, 5, 1, 2, 0, 0, 0, 0, 0, 0), none, 6, 0, 1, w);
        idle(10);
        chk("waw_stalls", 64'(stall_cycles - s0), 64'd5);

        for (int i = 0; i < 9; i++) begin
            idle(9);
            send_pair(vt[i].a, vt[i].b, vt[i].da, vt[i].db, 1, w);
            @(negedge clock);
            in_valid = 1'b0;
            ai = '0;
            bi = '0;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].rdy1));
        end
        idle(10);

        // Flush a stalled consumer: no issue, no stall counted, ready afterwards.
        s0 = stall_cycles;
        send_pair(mk(0, 9, 1, 7, 0, 0, 0, 0, 0, 0), none, 1, 0, 1, w);
        send_pair(mk(1, 11, 1, 1, 9, 1, 0, 0, 0, 0), none, 0, 0, 0, w);
        @(negedge clock);
        in_valid = 1'b0;
        ai = '0;
        branch_taken = 1'b1;
        #1;
        chk("flush_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clock);
        branch_taken = 1'b0;
        #1;
        chk("flush_no_issue", 64'({ep_valid, op_valid}), 64'd0);
        chk("flush_in_ready_after", 64'(in_ready), 64'd1);
        chk("flush_no_stall", 64'(stall_cycles - s0), 64'd0);

        // Flush an issuable pair while a new pair is offered: neither issues nor touches busy[].
        send_pair(mk(0, 20, 1, 7, 0, 0, 0, 0, 0, 0), mk(1, 21, 1, 7, 0, 0, 0, 0, 0, 0), 0, 0, 0, w);
        @(negedge clock);
        branch_taken = 1'b1;
        ai = mk(0, 50, 1, 1, 0, 0, 0, 0, 0, 0);
        bi = '0;
        in_valid = 1'b1;
        #1;
        chk("branch_blocks_accept", 64'(in_ready), 64'd0);
        @(negedge clock);
        branch_taken = 1'b0;
        in_valid = 1'b0;
        ai = '0;
        #1;
        chk("suppressed_no_issue", 64'({ep_valid, op_valid}), 64'd0);
        send_pair(mk(0, 60, 0, 1, 20, 1, 0, 0, 0, 0), mk(1, 61, 0, 1, 0, 0, 21, 1, 0, 0), 1, 1, 1, w);
        idle(10);

        // Reset during a stall clears slots, outputs, counter and scoreboard.
        send_pair(mk(0, 9, 1, 7, 0, 0, 0, 0, 0, 0), none, 1, 0, 1, w);
        send_pair(mk(1, 12, 1, 1, 9, 1, 0, 0, 0, 0), none, 0, 0, 0, w);
        @(negedge clock);
        in_valid = 1'b0;
        ai = '0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midreset_valids", 64'({ep_valid, op_valid}), 64'd0);
        chk("midreset_ep_zero", 64'(ep_rt) | ep_payload, 64'd0);
        chk("midreset_op_zero", 64'(op_rt) | op_payload, 64'd0);
        chk("midreset_stall", 64'(stall_cycles), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        send_pair(mk(0, 13, 1, 1, 9, 1, 0, 0, 0, 0), none, 1, 0, 1, w);
        idle(10);

        chk("ep_expected_drained", 64'(eq.size()), 64'd0);
        chk("op_expected_drained", 64'(oq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
